// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage. Owns the PC, absorbs the 1-cycle ROM
//            latency with an output register plus skid, supports redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int  DATA_LENGTH = 32,
    parameter int  MEM_LENGTH  = 32,
    localparam int ADDR_W      = $clog2(MEM_LENGTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_addr,
    output logic [ADDR_W-1:0]      mem_address,
    input  logic [DATA_LENGTH-1:0] mem_data,
    output logic [DATA_LENGTH-1:0] instr,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [ADDR_W-1:0]      pc
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(MEM_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_t;

    occ_t                   r_state;
    occ_t                   w_state_next;
    logic [ADDR_W-1:0]      r_pc;
    logic [ADDR_W-1:0]      r_pend_pc;
    logic                   r_pending;
    logic [DATA_LENGTH-1:0] r_instr;
    logic [ADDR_W-1:0]      r_instr_pc;
    logic [DATA_LENGTH-1:0] r_skid_data;
    logic [ADDR_W-1:0]      r_skid_pc;

    logic                   w_out_valid;
    logic                   w_skid_valid;
    logic                   w_consume;
    logic                   w_arrive;
    logic                   w_issue;
    logic                   w_load_out_mem;
    logic                   w_load_out_skid;
    logic                   w_load_skid;
    logic [ADDR_W-1:0]      w_next_pc;
    logic [ADDR_W-1:0]      w_redirect_pc;

    // Occupancy state is the single source of truth for both valid bits.
    assign w_out_valid  = (r_state != ST_EMPTY);
    assign w_skid_valid = (r_state == ST_TWO);
    assign w_consume    = w_out_valid && instr_ready;
    assign w_arrive     = r_pending && !redirect_valid;

    // Holding back issue while the output stalls with a word in flight keeps
    // the skid from ever being needed twice.
    assign w_issue = run && !redirect_valid && !w_skid_valid &&
                     !(w_out_valid && !instr_ready && r_pending);

    assign w_load_out_mem  = w_arrive && ((r_state == ST_EMPTY) ||
                                          ((r_state == ST_ONE) && w_consume));
    assign w_load_out_skid = !redirect_valid && w_skid_valid && w_consume;
    assign w_load_skid     = w_arrive && (r_state == ST_ONE) && !w_consume;

    assign w_next_pc = (r_pc == c_LAST) ? '0 : r_pc + ADDR_W'(1);

    generate
        if (MEM_LENGTH < (1 << ADDR_W)) begin : g_clamp
            assign w_redirect_pc = (redirect_addr > c_LAST) ? '0 : redirect_addr;
        end else begin : g_no_clamp
            assign w_redirect_pc = redirect_addr;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_arrive) w_state_next = ST_ONE;
                ST_ONE: begin
                    if (w_arrive && !w_consume) begin
                        w_state_next = ST_TWO;
                    end else if (!w_arrive && w_consume) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO:   if (w_consume) w_state_next = ST_ONE;
                default:  w_state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_pend_pc   <= '0;
            r_pending   <= 1'b0;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_skid_data <= '0;
            r_skid_pc   <= '0;
        end else begin
            r_pending <= w_issue;
            if (redirect_valid) begin
                r_pc <= w_redirect_pc;
            end else if (w_issue) begin
                r_pc      <= w_next_pc;
                r_pend_pc <= r_pc;
            end

            if (w_load_out_skid) begin
                r_instr    <= r_skid_data;
                r_instr_pc <= r_skid_pc;
            end else if (w_load_out_mem) begin
                r_instr    <= mem_data;
                r_instr_pc <= r_pend_pc;
            end

            if (w_load_skid) begin
                r_skid_data <= mem_data;
                r_skid_pc   <= r_pend_pc;
            end
        end
    end

    assign mem_address = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = w_out_valid;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of instruction_memory.
- Holds the program counter and drives the ROM word address.
- Absorbs the ROM's 1-cycle synchronous read latency and presents fetched instructions to decode over a valid/ready handshake.
- Supports stall from decode and PC redirect (branch/jump) with in-flight squash.

Parameters:
- DATA_LENGTH, 32, instruction width; must match instruction_memory DATA_LENGTH.
- MEM_LENGTH, 32, ROM depth in words; must match instruction_memory MEM_LENGTH. Derived localparam ADDR_W = $clog2(MEM_LENGTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- run  input  1  fetch enable; 0 = issue no new reads.
- redirect_valid  input  1  load PC from redirect_addr and flush.
- redirect_addr  input  ADDR_W  new word address.
- mem_address  output  ADDR_W  to instruction_memory address; equals the PC register, no combinational path from inputs.
- mem_data  input  DATA_LENGTH  from instruction_memory return_data.
- instr  output  DATA_LENGTH  fetched instruction (registered).
- instr_pc  output  ADDR_W  word address of instr.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts when valid&&ready at posedge.
- pc  output  ADDR_W  next fetch address (same as mem_address).

Behaviour:
- Reset (async, active-high): pc=0, pending=0, skid_valid=0, instr_valid=0, instr=0, instr_pc=0. Outputs are held at these values while rst=1.
- Issue condition: issue = run && !redirect_valid && !skid_valid && !(instr_valid && !instr_ready && pending).
- On issue: pending<=1, pend_pc<=pc, pc<=next_pc. Otherwise pending<=0 and pc holds.
- next_pc = (pc==MEM_LENGTH-1) ? 0 : pc+1. The wrap is explicit, so non-power-of-2 depths are correct.
- Return path: while pending=1, mem_data is the word at pend_pc.
  - Loads the output register (instr, instr_pc, instr_valid=1) if the output is empty or consumed this cycle (!instr_valid || instr_ready).
  - Otherwise loads the skid register.
- If skid_valid and the output is consumed, skid moves to the output; skid_valid<=0. The issue rule guarantees skid is empty whenever returning data needs it; an overflow is a design error, which the bench asserts.
- Occupancy FSM (output + skid): EMPTY -> ONE on data arrival; ONE -> TWO on arrival without consume; TWO -> ONE on consume; ONE -> EMPTY on consume with no arrival.
- Latency: issue in cycle N; mem_data is valid in N+1; instr_valid is high in N+2.
- Throughput: 1 instruction per cycle when run=1 and instr_ready=1 held.
- Order: instructions are delivered strictly in fetch order; no drop or duplicate under any instr_ready pattern.
- redirect_valid (highest priority, synchronous):
  - pc <= redirect_addr, or 0 if redirect_addr >= MEM_LENGTH.
  - pending, skid_valid and instr_valid cleared; the in-flight ROM word is discarded.
  - No issue in the redirect cycle; first issue of the target is the next cycle.
- redirect_valid with instr_valid&&instr_ready in the same cycle: the handshake completes (decode owns that instr), then the flush applies.
- run=0: no new issue. A pending word still completes into output or skid. Held data stays valid until consumed.
- instr and instr_pc are stable while instr_valid && !instr_ready.
- Reset asserted mid-operation: immediate clear. The first issue after release is address 0 in the first cycle with rst=0 and run=1.

Test Plan (bench ROM model: 1-cycle sync read, mem[i] = 32'h100+i):
- Reset release, run=1, ready=1 -> mem_address 0,1,2,... each cycle; instr_valid rises 2 cycles after first issue; instr=0x100,0x101,0x102 back-to-back with instr_pc 0,1,2.
- Stall: ready=0 for 4 cycles after first valid -> instr holds 0x100; pc stops after at most 2 further issues; on ready=1, sequence resumes 0x101,0x102 with no gap/drop/duplicate.
- Redirect to 20 while output and skid are full -> instr_valid=0 next cycle; next delivered instr=0x114 (pc 20), then 0x115; no stale 0x10x appears.
- Wrap, MEM_LENGTH=32: redirect to 30 -> delivered pcs 30,31,0,1. Repeat with MEM_LENGTH=20: redirect to 19 -> pcs 19,0; redirect to 25 -> pc 0.
- run=0 mid-stream -> at most 1 further word delivered, then instr_valid=0 after consume; run=1 resumes at the following pc.
- Random ready/run/redirect for 10k cycles vs reference queue model -> order and content match, skid overflow assertion never fires; async rst pulse mid-stall clears all outputs within the same cycle.
